decode_stage_modrm_fetch: RTL and testbench
===========================================

Name: decode_stage_modrm_fetch

Overview:
- Sequential byte collector between the prefetch queue and the combinational ModR/M and SIB decode stages.
- After the opcode stage signals that an instruction has a ModR/M byte, this block consumes, one byte per cycle, the ModR/M byte, the optional SIB byte and 0/1/2/4 displacement bytes.
- It presents the assembled fields to downstream address decode with a valid/ready handshake.
- Supports 16-bit and 32-bit address-size encodings.

Parameters:
- DISP_WIDTH, 32, width of the assembled, sign-extended displacement output.

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- i_flush  input  1  synchronous abort of the current collection
- i_start  input  1  start pulse from the opcode stage
- i_addr_size_32  input  1  address size for this instruction, sampled with i_start; 1 = 32-bit, 0 = 16-bit
- o_busy  output  1  high in every state except IDLE
- i_byte  input  8  next instruction byte from the prefetch queue
- i_byte_valid  input  1  i_byte is valid
- o_byte_ready  output  1  the block consumes i_byte this cycle if i_byte_valid is high
- o_modrm  output  8  captured ModR/M byte
- o_sib  output  8  captured SIB byte; 0 when absent
- o_sib_present  output  1  a SIB byte was consumed
- o_disp  output  DISP_WIDTH  sign-extended displacement, little-endian assembled
- o_disp_length  output  3  displacement byte count: 0, 1, 2 or 4
- o_ea_undefined  output  1  SIB index = 100 and ss != 00
- o_valid  output  1  output fields are valid
- i_ready  input  1  downstream accepts the output fields

Behaviour:
- Reset state: IDLE. All outputs 0, disp counter 0.
- States: IDLE, MODRM, SIB, DISP, OUT.
- A byte handshake occurs when o_byte_ready & i_byte_valid. o_byte_ready = 1 only in MODRM, SIB and DISP.
- IDLE: on i_start, latch i_addr_size_32, clear SIB/disp fields, go to MODRM. i_start is ignored in MODRM, SIB and DISP.
- MODRM handshake: capture o_modrm, then choose the next state:
  - mod=11 -> OUT, length 0.
  - 32-bit, rm=100 -> SIB.
  - 32-bit, mod=00, rm=101 -> DISP, length 4.
  - 32-bit, mod=01 -> DISP, length 1. mod=10 -> DISP, length 4. Otherwise -> OUT.
  - 16-bit: mod=00, rm=110 -> DISP, length 2; mod=01 -> length 1; mod=10 -> length 2. Otherwise -> OUT.
  - 16-bit never enters SIB.
- SIB handshake: capture o_sib, set o_sib_present, compute o_ea_undefined. Length from mod: 00 with base=101 -> 4; 00 otherwise -> 0 and go to OUT; 01 -> 1; 10 -> 4.
- DISP: each handshake writes byte k to bits [8k+7:8k], k = 0..length-1.
  - On the last byte, sign-extend from bit 8·length-1 to DISP_WIDTH, then go to OUT.
  - The counter is 2 bits and wraps only through reset/flush/restart.
- OUT: o_valid=1 and all output fields are held stable until i_ready.
  - On i_ready with no i_start -> IDLE.
  - On i_ready with i_start in the same cycle -> MODRM, latching the new address size. Fields are cleared the following cycle.
- Latency: o_valid rises the cycle after the final byte handshake.
  - Minimum 2 cycles from i_start: start, then a ModR/M byte with mod=11.
  - Stalls on i_byte_valid=0 add cycles one-for-one; the state is held.
- i_flush: from any state, next state IDLE; o_valid and o_busy drop the next cycle. A byte presented in the flush cycle is not consumed (o_byte_ready forced 0). reset has priority over i_flush.
- Displacement bytes beyond length are never consumed. Outputs change only on handshakes, start or flush.

Test Plan:
- 32-bit; bytes 44,24,F0 with i_byte_valid continuous -> o_modrm=44, o_sib=24, o_sib_present=1, o_disp=FFFFFFF0, o_disp_length=1, o_ea_undefined=0. o_valid rises 1 cycle after the F0 accept.
- 32-bit; bytes 05,78,56,34,12 -> o_sib_present=0, o_disp=12345678, length 4. Byte 0x13 presented afterwards is not consumed (o_byte_ready=0).
- 32-bit SIB cases:
  - Bytes 04,25,EF,BE,AD,DE -> o_disp=DEADBEEF, length 4, o_ea_undefined=0.
  - Bytes 04,61 -> length 0, o_ea_undefined=1.
- 16-bit cases:
  - 06,34,12 -> o_disp=00001234, length 2.
  - 46,80 -> o_disp=FFFFFF80, length 1.
  - 04 -> length 0 and no SIB.
- Handshake cases:
  - Byte C0 -> o_valid 2 cycles after i_start.
  - i_ready low for 3 cycles -> all outputs stable.
  - i_ready with i_start asserted -> back-to-back collection with no IDLE cycle.
  - i_byte_valid gaps of 2 cycles inside DISP -> correct assembly.
- Flush/reset cases:
  - i_flush after 2 of 4 disp bytes -> IDLE next cycle, o_busy=0, o_valid=0. A fresh start with 05,01,00,00,00 yields o_disp=00000001.
  - reset mid-SIB -> all outputs 0.

Source files
------------

// File: rtl/decode_stage_modrm_fetch.sv
// ModR/M, SIB and displacement byte collector between prefetch and EA decode.
// One byte per cycle in; assembled fields out over a valid/ready handshake.
module decode_stage_modrm_fetch #(
  parameter int DISP_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_flush,
  input  logic                  i_start,
  input  logic                  i_addr_size_32,
  output logic                  o_busy,
  input  logic [7:0]            i_byte,
  input  logic                  i_byte_valid,
  output logic                  o_byte_ready,
  output logic [7:0]            o_modrm,
  output logic [7:0]            o_sib,
  output logic                  o_sib_present,
  output logic [DISP_WIDTH-1:0] o_disp,
  output logic [2:0]            o_disp_length,
  output logic                  o_ea_undefined,
  output logic                  o_valid,
  input  logic                  i_ready
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MODRM = 3'd1;
  localparam logic [2:0] S_SIB   = 3'd2;
  localparam logic [2:0] S_DISP  = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  logic [2:0]            state_q, state_d;
  logic                  addr32_q, addr32_d;
  logic [7:0]            modrm_q, modrm_d;
  logic [7:0]            sib_q, sib_d;
  logic                  sib_present_q, sib_present_d;
  logic [DISP_WIDTH-1:0] disp_q, disp_d;
  logic [2:0]            len_q, len_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  ea_undef_q, ea_undef_d;

  logic                  collecting;
  logic                  byte_hs;
  logic                  do_start;
  logic [1:0]            mod_b;
  logic [2:0]            rm_b;
  logic [5:0]            nbits;
  logic [DISP_WIDTH-1:0] mask;
  logic                  sign;

  assign collecting = (state_q == S_MODRM) ||
                      (state_q == S_SIB) ||
                      (state_q == S_DISP);
  assign byte_hs = collecting && !i_flush && i_byte_valid;
  assign mod_b   = i_byte[7:6];
  assign rm_b    = i_byte[2:0];

  always_comb begin
    state_d       = state_q;
    addr32_d      = addr32_q;
    modrm_d       = modrm_q;
    sib_d         = sib_q;
    sib_present_d = sib_present_q;
    disp_d        = disp_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    ea_undef_d    = ea_undef_q;
    do_start      = 1'b0;
    nbits         = {len_q, 3'b000};
    mask          = (DISP_WIDTH'(1) << nbits) - DISP_WIDTH'(1);
    sign          = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d  = S_MODRM;
          do_start = 1'b1;
        end
      end
      S_MODRM: begin
        if (byte_hs) begin
          modrm_d = i_byte;
          state_d = S_OUT;
          if (mod_b == 2'b11) begin
            state_d = S_OUT;
          end else if (addr32_q) begin
            if (rm_b == 3'b100) begin
              state_d = S_SIB;
            end else if (mod_b == 2'b00 && rm_b == 3'b101) begin
              state_d = S_DISP;
              len_d   = 3'd4;
            end else if (mod_b == 2'b01) begin
              state_d = S_DISP;
              len_d   = 3'd1;
            end else if (mod_b == 2'b10) begin
              state_d = S_DISP;
              len_d   = 3'd4;
            end
          end else begin
            if (mod_b == 2'b00 && rm_b == 3'b110) begin
              state_d = S_DISP;
              len_d   = 3'd2;
            end else if (mod_b == 2'b01) begin
              state_d = S_DISP;
              len_d   = 3'd1;
            end else if (mod_b == 2'b10) begin
              state_d = S_DISP;
              len_d   = 3'd2;
            end
          end
        end
      end
      S_SIB: begin
        if (byte_hs) begin
          sib_d         = i_byte;
          sib_present_d = 1'b1;
          ea_undef_d    = (i_byte[5:3] == 3'b100) && (i_byte[7:6] != 2'b00);
          // displacement size follows the ModR/M mod field, not the SIB byte
          unique case (modrm_q[7:6])
            2'b00: begin
              if (rm_b == 3'b101) begin
                state_d = S_DISP;
                len_d   = 3'd4;
              end else begin
                state_d = S_OUT;
                len_d   = 3'd0;
              end
            end
            2'b01: begin
              state_d = S_DISP;
              len_d   = 3'd1;
            end
            default: begin
              state_d = S_DISP;
              len_d   = 3'd4;
            end
          endcase
        end
      end
      S_DISP: begin
        if (byte_hs) begin
          for (int k = 0; k < 4; k++) begin
            if (cnt_q == 2'(k)) disp_d[8*k +: 8] = i_byte;
          end
          cnt_d = cnt_q + 2'd1;
          if (({1'b0, cnt_q} + 3'd1) == len_q) begin
            unique case (len_q)
              3'd1:    sign = disp_d[7];
              3'd2:    sign = disp_d[15];
              default: sign = disp_d[31];
            endcase
            disp_d  = sign ? (disp_d | ~mask) : (disp_d & mask);
            state_d = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (i_ready) begin
          state_d  = i_start ? S_MODRM : S_IDLE;
          do_start = i_start;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (do_start) begin
      addr32_d      = i_addr_size_32;
      sib_d         = 8'h00;
      sib_present_d = 1'b0;
      disp_d        = '0;
      len_d         = 3'd0;
      cnt_d         = 2'd0;
      ea_undef_d    = 1'b0;
    end

    if (i_flush) begin
      state_d       = S_IDLE;
      addr32_d      = 1'b0;
      modrm_d       = 8'h00;
      sib_d         = 8'h00;
      sib_present_d = 1'b0;
      disp_d        = '0;
      len_d         = 3'd0;
      cnt_d         = 2'd0;
      ea_undef_d    = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      addr32_q      <= 1'b0;
      modrm_q       <= 8'h00;
      sib_q         <= 8'h00;
      sib_present_q <= 1'b0;
      disp_q        <= '0;
      len_q         <= 3'd0;
      cnt_q         <= 2'd0;
      ea_undef_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr32_q      <= addr32_d;
      modrm_q       <= modrm_d;
      sib_q         <= sib_d;
      sib_present_q <= sib_present_d;
      disp_q        <= disp_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      ea_undef_q    <= ea_undef_d;
    end
  end

  assign o_busy         = (state_q != S_IDLE);
  assign o_byte_ready   = collecting && !i_flush;
  assign o_valid        = (state_q == S_OUT);
  assign o_modrm        = modrm_q;
  assign o_sib          = sib_q;
  assign o_sib_present  = sib_present_q;
  assign o_disp         = disp_q;
  assign o_disp_length  = len_q;
  assign o_ea_undefined = ea_undef_q;

endmodule

// File: tb/tb_decode_stage_modrm_fetch.sv
// Directed-vector bench for decode_stage_modrm_fetch.
// Expected field bundles queue up at stimulus time; a negedge monitor checks them.
module tb_decode_stage_modrm_fetch;

  logic        clock;
  logic        reset;
  logic        i_flush;
  logic        i_start;
  logic        i_addr_size_32;
  logic        o_busy;
  logic [7:0]  i_byte;
  logic        i_byte_valid;
  logic        o_byte_ready;
  logic [7:0]  o_modrm;
  logic [7:0]  o_sib;
  logic        o_sib_present;
  logic [31:0] o_disp;
  logic [2:0]  o_disp_length;
  logic        o_ea_undefined;
  logic        o_valid;
  logic        i_ready;

  typedef struct packed {
    logic [7:0]  modrm;
    logic [7:0]  sib;
    logic        sp;
    logic [31:0] disp;
    logic [2:0]  len;
    logic        ea;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk;
  int   n_fail;

  decode_stage_modrm_fetch #(.DISP_WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .i_flush        (i_flush),
    .i_start        (i_start),
    .i_addr_size_32 (i_addr_size_32),
    .o_busy         (o_busy),
    .i_byte         (i_byte),
    .i_byte_valid   (i_byte_valid),
    .o_byte_ready   (o_byte_ready),
    .o_modrm        (o_modrm),
    .o_sib          (o_sib),
    .o_sib_present  (o_sib_present),
    .o_disp         (o_disp),
    .o_disp_length  (o_disp_length),
    .o_ea_undefined (o_ea_undefined),
    .o_valid        (o_valid),
    .i_ready        (i_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] m, input logic [7:0] s,
                      input logic sp, input logic [31:0] d,
                      input logic [2:0] l, input logic ea);
    exp_t e;
    e.modrm = m;
    e.sib   = s;
    e.sp    = sp;
    e.disp  = d;
    e.len   = l;
    e.ea    = ea;
    exp_q.push_back(e);
  endtask

  always @(negedge clock) begin
    exp_t act;
    if (!reset && o_valid) begin
      act = {o_modrm, o_sib, o_sib_present, o_disp, o_disp_length,
             o_ea_undefined};
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid: got modrm=%h with no expected entry",
                 o_modrm);
      end else begin
        if (act !== exp_q[0]) begin
          n_fail++;
          $display("FAIL out_fields: got m=%h s=%h sp=%b d=%h l=%0d ea=%b expected m=%h s=%h sp=%b d=%h l=%0d ea=%b",
                   act.modrm, act.sib, act.sp, act.disp, act.len, act.ea,
                   exp_q[0].modrm, exp_q[0].sib, exp_q[0].sp,
                   exp_q[0].disp, exp_q[0].len, exp_q[0].ea);
        end
        if (i_ready && !i_flush) void'(exp_q.pop_front());
      end
    end
  end

  task automatic start(input logic a32);
    i_start        = 1'b1;
    i_addr_size_32 = a32;
    @(posedge clock); #1;
    i_start = 1'b0;
  endtask

  task automatic feed(input logic [7:0] b, input int gap);
    int t;
    i_byte_valid = 1'b0;
    repeat (gap) begin
      @(posedge clock); #1;
    end
    i_byte       = b;
    i_byte_valid = 1'b1;
    t = 0;
    while (!o_byte_ready && t < 20) begin
      @(posedge clock); #1;
      t++;
    end
    chk("feed_ready", 64'(o_byte_ready), 64'(1));
    @(posedge clock); #1;
  endtask

  task automatic drain();
    int t;
    i_byte_valid = 1'b0;
    i_ready      = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(posedge clock); #1;
      t++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
    chk("drain_idle", 64'({o_busy, o_valid}), 64'(0));
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, 64'({o_busy, o_byte_ready, o_modrm, o_sib, o_sib_present,
                 o_disp, o_disp_length, o_ea_undefined, o_valid}), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_chk          = 0;
    n_fail         = 0;
    reset          = 1'b1;
    i_flush        = 1'b0;
    i_start        = 1'b0;
    i_addr_size_32 = 1'b0;
    i_byte         = 8'h00;
    i_byte_valid   = 1'b0;
    i_ready        = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    chk_all_zero("reset_state");

    // 32-bit SIB with disp8
    push(8'h44, 8'h24, 1'b1, 32'hFFFF_FFF0, 3'd1, 1'b0);
    start(1'b1);
    feed(8'h44, 0);
    feed(8'h24, 0);
    chk("t1_no_early_valid", 64'(o_valid), 64'(0));
    feed(8'hF0, 0);
    chk("t1_valid_latency", 64'(o_valid), 64'(1));
    drain();

    // 32-bit disp32, surplus byte must not be taken
    push(8'h05, 8'h00, 1'b0, 32'h1234_5678, 3'd4, 1'b0);
    start(1'b1);
    feed(8'h05, 0);
    feed(8'h78, 0);
    feed(8'h56, 0);
    feed(8'h34, 0);
    i_ready = 1'b0;
    feed(8'h12, 0);
    i_byte       = 8'h13;
    i_byte_valid = 1'b1;
    repeat (3) begin
      chk("t2_no_consume", 64'(o_byte_ready), 64'(0));
      @(posedge clock); #1;
    end
    drain();

    // SIB base=101 disp32, stalled output, then back-to-back start
    push(8'h04, 8'h25, 1'b1, 32'hDEAD_BEEF, 3'd4, 1'b0);
    start(1'b1);
    feed(8'h04, 0);
    feed(8'h25, 0);
    feed(8'hEF, 0);
    feed(8'hBE, 0);
    feed(8'hAD, 0);
    i_ready = 1'b0;
    feed(8'hDE, 0);
    repeat (3) begin
      @(posedge clock); #1;
    end
    chk("stall_valid_held", 64'(o_valid), 64'(1));
    push(8'h06, 8'h00, 1'b0, 32'h0000_1234, 3'd2, 1'b0);
    i_start        = 1'b1;
    i_addr_size_32 = 1'b0;
    i_ready        = 1'b1;
    @(posedge clock); #1;
    i_start = 1'b0;
    chk("b2b_busy", 64'(o_busy), 64'(1));
    chk("b2b_valid_low", 64'(o_valid), 64'(0));
    chk("b2b_cleared", 64'({o_sib, o_sib_present, o_disp, o_disp_length}),
        64'(0));
    feed(8'h06, 0);
    feed(8'h34, 0);
    feed(8'h12, 0);
    drain();

    // SIB index=100 with nonzero scale
    push(8'h04, 8'h61, 1'b1, 32'h0, 3'd0, 1'b1);
    start(1'b1);
    feed(8'h04, 0);
    feed(8'h61, 0);
    chk("t4_valid", 64'(o_valid), 64'(1));
    drain();

    // 16-bit disp8 sign-extended
    push(8'h46, 8'h00, 1'b0, 32'hFFFF_FF80, 3'd1, 1'b0);
    start(1'b0);
    feed(8'h46, 0);
    feed(8'h80, 0);
    drain();

    // 16-bit rm=100 never takes a SIB
    push(8'h04, 8'h00, 1'b0, 32'h0, 3'd0, 1'b0);
    start(1'b0);
    feed(8'h04, 0);
    chk("t6_valid", 64'(o_valid), 64'(1));
    drain();

    // minimum latency with register operand
    push(8'hC0, 8'h00, 1'b0, 32'h0, 3'd0, 1'b0);
    start(1'b1);
    chk("c0_busy", 64'(o_busy), 64'(1));
    chk("c0_early_valid", 64'(o_valid), 64'(0));
    feed(8'hC0, 0);
    chk("c0_valid_2cyc", 64'(o_valid), 64'(1));
    drain();

    // gaps between displacement bytes
    push(8'h85, 8'h00, 1'b0, 32'h4433_2211, 3'd4, 1'b0);
    start(1'b1);
    feed(8'h85, 0);
    feed(8'h11, 2);
    feed(8'h22, 2);
    feed(8'h33, 2);
    feed(8'h44, 2);
    drain();

    // flush half way through disp32
    start(1'b1);
    feed(8'h05, 0);
    feed(8'hAA, 0);
    feed(8'hBB, 0);
    i_byte       = 8'hCC;
    i_byte_valid = 1'b1;
    i_flush      = 1'b1;
    #1;
    chk("flush_no_ready", 64'(o_byte_ready), 64'(0));
    @(posedge clock); #1;
    i_flush      = 1'b0;
    i_byte_valid = 1'b0;
    chk("flush_busy", 64'(o_busy), 64'(0));
    chk("flush_valid", 64'(o_valid), 64'(0));
    push(8'h05, 8'h00, 1'b0, 32'h0000_0001, 3'd4, 1'b0);
    start(1'b1);
    feed(8'h05, 0);
    feed(8'h01, 0);
    feed(8'h00, 0);
    feed(8'h00, 0);
    feed(8'h00, 0);
    drain();

    // reset while waiting for the SIB byte
    start(1'b1);
    feed(8'h44, 0);
    chk("pre_reset_busy", 64'(o_busy), 64'(1));
    reset = 1'b1;
    @(posedge clock); #1;
    reset        = 1'b0;
    i_byte_valid = 1'b0;
    chk_all_zero("reset_mid_sib");

    repeat (2) @(posedge clock);
    #1;
    chk("final_queue_empty", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
